spi_display_master: RTL

SPI master that streams a full display frame from a local pixel buffer into the display controller's SPI slave. It is the transmit end of that slave's link. Per row it sends one ss frame: command 0xF0, then columns×3 pixel bytes. After the last row it sends a one-byte 0x10 frame so the slave asserts loaded. It sits between the frame composer's buffer read port and the panel board's SPI pins.

---
 rtl/display_pkg.sv | 28 ++
 rtl/spi_byte_shifter.sv | 65 ++++++
 rtl/spi_display_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the SPI display frame streamer:
// command bytes, pixel geometry and FSM encodings.
package display_pkg;

    localparam logic [7:0] CMD_WRITE_ROW = 8'hF0;
    localparam logic [7:0] CMD_LOAD      = 8'h10;

    localparam int CHAN_W  = 8;
    localparam int PIXEL_W = 3 * CHAN_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_FIN
    } state_t;

    // Which byte the shifter is currently sending within a row frame.
    typedef enum logic [1:0] {
        SRC_CMD,
        SRC_CH2,
        SRC_CH1,
        SRC_CH0
    } src_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// Serialises one byte MSB first: sclk low for clkdiv cycles, then high for clkdiv cycles per bit.
// byte_done marks the last high-phase cycle so the next byte can be loaded back-to-back.
module spi_byte_shifter #(
    parameter int clkdiv = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_done
);

    localparam int DW = (clkdiv > 1) ? $clog2(clkdiv) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(clkdiv - 1);

    logic          active;
    logic [7:0]    sh;
    logic [2:0]    bit_idx;
    logic [DW-1:0] div_cnt;
    logic          phase_end;

    assign phase_end = (div_cnt == DIV_LAST);
    assign byte_done = active && sclk && phase_end && (bit_idx == 3'd7);

    // NOTE: every register here is written with <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            sh      <= '0;
            bit_idx <= '0;
            div_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (load) begin
            active  <= 1'b1;
            mosi    <= data[7];
            sh      <= {data[6:0], 1'b0};
            bit_idx <= '0;
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    // mosi only moves here, as sclk drops into the next bit's low phase
                    sclk <= 1'b0;
                    if (bit_idx == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        mosi    <= sh[7];
                        sh      <= {sh[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_display_master.sv
// Streams a frame from the pixel buffer as one SPI frame per row (0xF0 + pixels) plus a 0x10 load frame.
// Define SPI_MASTER_PREFETCH_EN to fetch the next pixel during ch0 and remove the 2-cycle inter-pixel stall.
module spi_display_master
    import display_pkg::*;
#(
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8,
    parameter int clkdiv   = 1,
    parameter int gap      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(rows)-1:0]    rrow,
    output logic [$clog2(columns)-1:0] rcol,
    output logic                       ren,
    input  logic [3*bitwidth-1:0]      rdata,
    output logic                       sclk,
    output logic                       ss,
    output logic                       mosi
);

`ifdef SPI_MASTER_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    localparam int RW = $clog2(rows);
    localparam int CW = $clog2(columns);
    localparam int GW = (gap > 1) ? $clog2(gap) : 1;

    state_t             state;
    src_t               src;
    logic [RW-1:0]      row_cnt;
    logic [CW-1:0]      col_cnt;
    logic               load_frame;
    logic               ren_d;
    logic               stall;
    logic [PIXEL_W-1:0] pix;
    logic [GW-1:0]      gap_cnt;

    logic               shift_load;
    logic [7:0]         shift_data;
    logic               byte_done;
    logic               last_col;
    logic               last_row;

    assign last_col = (col_cnt == CW'(columns - 1));
    assign last_row = (row_cnt == RW'(rows - 1));

    // NOTE: both outputs get a default before the case, so no path leaves them unassigned (no latch).
    always_comb begin
        shift_load = 1'b0;
        shift_data = pix[23:16];
        case (state)
            ST_SETUP: begin
                shift_load = 1'b1;
                shift_data = load_frame ? CMD_LOAD : CMD_WRITE_ROW;
            end
            ST_SHIFT: begin
                if (byte_done) begin
                    case (src)
                        SRC_CMD: shift_load = !load_frame;
                        SRC_CH2: begin
                            shift_load = 1'b1;
                            shift_data = pix[15:8];
                        end
                        SRC_CH1: begin
                            shift_load = 1'b1;
                            shift_data = pix[7:0];
                        end
                        SRC_CH0: shift_load = PREFETCH && !last_col;
                    endcase
                end else if (stall && ren_d) begin
                    // Stalled fetch: the holding register is not yet updated, so take ch2 straight off the bus.
                    shift_load = 1'b1;
                    shift_data = rdata[23:16];
                end
            end
            default: ;
        endcase
    end

    spi_byte_shifter #(
        .clkdiv(clkdiv)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (shift_load),
        .data     (shift_data),
        .sclk     (sclk),
        .mosi     (mosi),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            src        <= SRC_CMD;
            busy       <= 1'b0;
            done       <= 1'b0;
            ren        <= 1'b0;
            rrow       <= '0;
            rcol       <= '0;
            ss         <= 1'b0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            load_frame <= 1'b0;
            ren_d      <= 1'b0;
            stall      <= 1'b0;
            pix        <= '0;
            gap_cnt    <= '0;
        end else begin
            ren   <= 1'b0;
            done  <= 1'b0;
            ren_d <= ren;
            if (ren_d) pix <= rdata;

            // Fetch address walks the buffer in raster order and wraps to (0,0) after the last pixel.
            if (ren) begin
                if (rcol == CW'(columns - 1)) begin
                    rcol <= '0;
                    rrow <= (rrow == RW'(rows - 1)) ? '0 : rrow + RW'(1);
                end else begin
                    rcol <= rcol + CW'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETUP;
                        busy       <= 1'b1;
                        ss         <= 1'b1;
                        ren        <= 1'b1;
                        row_cnt    <= '0;
                        col_cnt    <= '0;
                        load_frame <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state <= ST_SHIFT;
                    src   <= SRC_CMD;
                end
                ST_SHIFT: begin
                    if (byte_done) begin
                        case (src)
                            SRC_CMD: begin
                                if (load_frame) state <= ST_HOLD;
                                else            src   <= SRC_CH2;
                            end
                            SRC_CH2: src <= SRC_CH1;
                            SRC_CH1: begin
                                src <= SRC_CH0;
                                if (PREFETCH && !last_col) ren <= 1'b1;
                            end
                            SRC_CH0: begin
                                if (last_col) begin
                                    state   <= ST_HOLD;
                                    col_cnt <= '0;
                                end else begin
                                    col_cnt <= col_cnt + CW'(1);
                                    src     <= SRC_CH2;
                                    if (!PREFETCH) begin
                                        ren   <= 1'b1;
                                        stall <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end else if (stall && ren_d) begin
                        stall <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    ss      <= 1'b0;
                    state   <= ST_GAP;
                    gap_cnt <= '0;
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(gap - 1)) begin
                        if (load_frame) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SETUP;
                            ss    <= 1'b1;
                            if (last_row) begin
                                load_frame <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + RW'(1);
                                ren     <= 1'b1;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
